// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing defaults, derived sync window helpers and the 12-bit colour type
// shared by the VGA scan controller and its pixel-clock divider.
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam int CNT_W = 10;

  typedef logic [11:0] rgb_t;

  function automatic logic [3:0] red_of(input rgb_t c);
    return c[11:8];
  endfunction

  function automatic logic [3:0] green_of(input rgb_t c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] blue_of(input rgb_t c);
    return c[3:0];
  endfunction

  // True while a scan counter sits inside [start, end) of a sync pulse.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] last_excl);
    return (cnt >= first) && (cnt < last_excl);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Divides the system clock by CLK_DIV into a one-clock pixel strobe; the strobe is
// registered so it is guaranteed low while reset is held.
`timescale 1ns/1ps
module pixel_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  always_comb begin
    div_next = (div == LAST) ? '0 : div + DW'(1);
  end

  // pix_en is high exactly in the clock where div holds its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_next;
      pix_en <= (div_next == LAST);
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan sequencer: pixel strobe, h/v scan counters, coordinate publication and a
// registered colour/sync output stage that keeps RGB, HS and VS mutually aligned.
`timescale 1ns/1ps
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        MAX10_CLK1_50,
  input  logic        KEY0,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pix_en,
  output logic        pix_active,
  output logic        frame_start,
  output logic        vblank,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_FIN = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_FIN = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  rgb_t             rgb_q;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .clk    (MAX10_CLK1_50),
    .rst_n  (KEY0),
    .pix_en (pix_en)
  );

  // A line wrap and a frame wrap on the same strobe collapse into one update.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign pixel_x    = h_cnt;
  assign pixel_y    = v_cnt;
  assign pix_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign vblank     = (v_cnt >= V_ACT);

  // Sampling on the strobe that ends the pixel gives a one-pixel colour latency, and
  // decoding sync from the same counts keeps HS/VS aligned with that delayed colour.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      rgb_q       <= '0;
      VGA_HS      <= ~SYNC_POL;
      VGA_VS      <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (pix_en) begin
        rgb_q  <= pix_active ? rgb_t'(rgb_in) : '0;
        VGA_HS <= in_window(h_cnt, H_SYNC_BEG, H_SYNC_FIN) ? SYNC_POL : ~SYNC_POL;
        VGA_VS <= in_window(v_cnt, V_SYNC_BEG, V_SYNC_FIN) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign VGA_R = red_of(rgb_q);
  assign VGA_G = green_of(rgb_q);
  assign VGA_B = blue_of(rgb_q);

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a full 640x480 instance and a shrunken-timing instance
// (so whole frames fit in a short run) checked every clock against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_scan_controller;

  typedef struct {
    int cd, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  } timing_t;

  typedef struct {
    int          x, y;
    bit          pix_en, active, vblank, frame_start, hs, vs;
    logic [11:0] rgb;
  } exp_t;

  localparam timing_t FULL_T  = '{cd: 2, ha: 640, hfp: 16, hsw: 96, hbp: 48,
                                  va: 480, vfp: 10, vsw: 2, vbp: 33};
  localparam timing_t SMALL_T = '{cd: 2, ha: 16, hfp: 4, hsw: 6, hbp: 4,
                                  va: 10, vfp: 2, vsw: 2, vbp: 3};

  logic        clk = 1'b0;
  logic        key0;
  bit          mode;
  int          n = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          fs_count = 0;

  logic [11:0] rgb_full, rgb_small;
  logic [9:0]  full_x, full_y, small_x, small_y;
  logic        full_pe, full_act, full_fs, full_vb, full_hs, full_vs;
  logic        small_pe, small_act, small_fs, small_vb, small_hs, small_vs;
  logic [3:0]  full_r, full_g, full_b, small_r, small_g, small_b;
  exp_t        e_full, e_small;

  always #10 clk = ~clk;

  vga_scan_controller u_full (
    .MAX10_CLK1_50 (clk),      .KEY0        (key0),     .rgb_in (rgb_full),
    .pixel_x       (full_x),   .pixel_y     (full_y),   .pix_en (full_pe),
    .pix_active    (full_act), .frame_start (full_fs),  .vblank (full_vb),
    .VGA_R         (full_r),   .VGA_G       (full_g),   .VGA_B  (full_b),
    .VGA_HS        (full_hs),  .VGA_VS      (full_vs)
  );

  vga_scan_controller #(
    .CLK_DIV (2), .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (4),
    .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3), .SYNC_POL (1'b0)
  ) u_small (
    .MAX10_CLK1_50 (clk),       .KEY0        (key0),     .rgb_in (rgb_small),
    .pixel_x       (small_x),   .pixel_y     (small_y),  .pix_en (small_pe),
    .pix_active    (small_act), .frame_start (small_fs), .vblank (small_vb),
    .VGA_R         (small_r),   .VGA_G       (small_g),  .VGA_B  (small_b),
    .VGA_HS        (small_hs),  .VGA_VS      (small_vs)
  );

  function automatic logic [11:0] color_of(input bit m, input int x, input int y);
    logic [3:0] xl, yl;
    xl = x[3:0];
    yl = y[3:0];
    return m ? {xl, yl, xl ^ yl} : 12'hF0A;
  endfunction

  // n rising edges since reset release: n/cd pixels have elapsed, and the registered
  // outputs describe the pixel before the current one.
  function automatic exp_t model(input int edges, input timing_t t, input bit m);
    exp_t e;
    int ht, vt, frame, p, pos, prev, px, py;
    ht    = t.ha + t.hfp + t.hsw + t.hbp;
    vt    = t.va + t.vfp + t.vsw + t.vbp;
    frame = ht * vt;
    p     = edges / t.cd;
    pos   = p % frame;
    e.x      = pos % ht;
    e.y      = pos / ht;
    e.pix_en = (edges % t.cd) == (t.cd - 1);
    e.active = (e.x < t.ha) && (e.y < t.va);
    e.vblank = (e.y >= t.va);
    e.frame_start = (p > 0) && ((edges % t.cd) == 0) && (pos == 0);
    if (p == 0) begin
      e.rgb = 12'h000;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
    end else begin
      prev = (p - 1) % frame;
      px   = prev % ht;
      py   = prev / ht;
      e.rgb = ((px < t.ha) && (py < t.va)) ? color_of(m, px, py) : 12'h000;
      e.hs  = !((px >= t.ha + t.hfp) && (px < t.ha + t.hfp + t.hsw));
      e.vs  = !((py >= t.va + t.vfp) && (py < t.va + t.vfp + t.vsw));
    end
    return e;
  endfunction

  always @(posedge clk or negedge key0) begin
    if (!key0) n <= 0;
    else       n <= n + 1;
  end

  always_comb begin
    e_full    = model(n, FULL_T, mode);
    e_small   = model(n, SMALL_T, mode);
    rgb_full  = color_of(mode, e_full.x, e_full.y);
    rgb_small = color_of(mode, e_small.x, e_small.y);
  end

  always @(negedge clk) begin
    if (!key0) fs_count <= 0;
    else if (small_fs) fs_count <= fs_count + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("full.pixel_x",     int'(full_x),   e_full.x);
    checkOutput("full.pixel_y",     int'(full_y),   e_full.y);
    checkOutput("full.pix_en",      int'(full_pe),  int'(e_full.pix_en));
    checkOutput("full.pix_active",  int'(full_act), int'(e_full.active));
    checkOutput("full.vblank",      int'(full_vb),  int'(e_full.vblank));
    checkOutput("full.frame_start", int'(full_fs),  int'(e_full.frame_start));
    checkOutput("full.rgb",         int'({full_r, full_g, full_b}), int'(e_full.rgb));
    checkOutput("full.hs",          int'(full_hs),  int'(e_full.hs));
    checkOutput("full.vs",          int'(full_vs),  int'(e_full.vs));
    checkOutput("small.pixel_x",     int'(small_x),   e_small.x);
    checkOutput("small.pixel_y",     int'(small_y),   e_small.y);
    checkOutput("small.pix_en",      int'(small_pe),  int'(e_small.pix_en));
    checkOutput("small.pix_active",  int'(small_act), int'(e_small.active));
    checkOutput("small.vblank",      int'(small_vb),  int'(e_small.vblank));
    checkOutput("small.frame_start", int'(small_fs),  int'(e_small.frame_start));
    checkOutput("small.rgb",         int'({small_r, small_g, small_b}), int'(e_small.rgb));
    checkOutput("small.hs",          int'(small_hs),  int'(e_small.hs));
    checkOutput("small.vs",          int'(small_vs),  int'(e_small.vs));
  end

  function automatic bit sig(input int which);
    return (which == 0) ? full_hs : small_vs;
  endfunction

  task automatic wait_level(input int which, input bit level, input int budget,
                            output time t_hit);
    bit hit;
    hit   = 1'b0;
    t_hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (sig(which) == level) begin
        hit   = 1'b1;
        t_hit = $time;
      end
    end
    if (!hit) checkOutput("wait_level_timeout", 0, 1);
  endtask

  task automatic wait_small_at(input int x, input int y, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (int'(small_x) == x && int'(small_y) == y && small_pe) hit = 1'b1;
    end
    if (!hit) checkOutput("wait_small_at_timeout", 0, 1);
  endtask

  task automatic wait_edges(input int target, input int budget);
    for (int i = 0; i < budget && n < target; i++) @(negedge clk);
    if (n < target) checkOutput("wait_edges_timeout", n, target);
  endtask

  task automatic applyStimulus();
    time t_fall, t_rise, t_fall2;

    // Reset held, then released off-edge at 25 ns.
    #15;
    checkOutput("rst.rgb", int'({full_r, full_g, full_b}), 0);
    checkOutput("rst.hs", int'(full_hs), 1);
    checkOutput("rst.vs", int'(full_vs), 1);
    checkOutput("rst.pix_en", int'(full_pe), 0);
    #10 key0 = 1'b1;

    @(negedge clk);
    checkOutput("t40.pix_en", int'(full_pe), 1);
    checkOutput("t40.pixel_x", int'(full_x), 0);
    checkOutput("t40.rgb", int'({full_r, full_g, full_b}), 0);
    @(negedge clk);
    checkOutput("t60.pixel_x", int'(full_x), 1);
    checkOutput("t60.rgb", int'({full_r, full_g, full_b}), 12'hF0A);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t100.pixel_x", int'(full_x), 2);

    // Horizontal sync timing on the full-size instance.
    wait_level(0, 1'b0, 2000, t_fall);
    checkOutput("hs.first_fall_time", int'(t_fall), 26300);
    checkOutput("hs.first_fall_x", int'(full_x), 657);
    wait_level(0, 1'b1, 400, t_rise);
    checkOutput("hs.low_ns", int'(t_rise - t_fall), 3840);
    wait_level(0, 1'b0, 2000, t_fall2);
    checkOutput("hs.period_ns", int'(t_fall2 - t_fall), 32000);

    // Patterned colour on the shrunken instance across whole frames.
    @(posedge clk);
    #5 key0 = 1'b0;
    mode = 1'b1;
    #30;
    @(posedge clk);
    #5 key0 = 1'b1;

    wait_level(1, 1'b0, 1000, t_fall);
    checkOutput("vs.fall_y", int'(small_y), 12);
    checkOutput("vs.fall_x", int'(small_x), 1);
    wait_level(1, 1'b1, 400, t_rise);
    checkOutput("vs.low_ns", int'(t_rise - t_fall), 2400);
    wait_level(1, 1'b0, 1200, t_fall2);
    checkOutput("vs.period_ns", int'(t_fall2 - t_fall), 20400);

    wait_small_at(29, 16, 1200);
    checkOutput("wrap.vblank_before", int'(small_vb), 1);
    @(negedge clk);
    checkOutput("wrap.x", int'(small_x), 0);
    checkOutput("wrap.y", int'(small_y), 0);
    checkOutput("wrap.frame_start", int'(small_fs), 1);
    checkOutput("wrap.vblank_after", int'(small_vb), 0);
    @(negedge clk);
    checkOutput("wrap.frame_start_drop", int'(small_fs), 0);

    wait_edges(3070, 1200);
    @(negedge clk);
    checkOutput("frames.frame_start_count", fs_count, 3);

    // Mid-frame asynchronous reset, then restart from (0,0).
    wait_small_at(7, 5, 1200);
    @(posedge clk);
    #5 key0 = 1'b0;
    #1;
    checkOutput("midrst.x", int'(small_x), 0);
    checkOutput("midrst.y", int'(small_y), 0);
    checkOutput("midrst.rgb", int'({small_r, small_g, small_b}), 0);
    checkOutput("midrst.hs", int'(small_hs), 1);
    checkOutput("midrst.pix_en", int'(small_pe), 0);
    checkOutput("midrst.full_x", int'(full_x), 0);
    #28;
    @(posedge clk);
    #5 key0 = 1'b1;
    wait_edges(1019, 1200);
    checkOutput("midrst.no_early_frame_start", fs_count, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst.first_frame_start", fs_count, 1);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    key0 = 1'b0;
    mode = 1'b0;
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
